// File: rtl/prog_loader_pkg.sv
// Shared constants and FSM state encoding for the program loader.
package prog_loader_pkg;

  localparam logic [7:0]  LOADER_SYNC    = 8'hA5;
  localparam logic [7:0]  LOADER_ACK     = 8'h06;
  localparam logic [7:0]  LOADER_NAK     = 8'h15;
  localparam logic [31:0] MEM_INSTR_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    RESP
  } loader_state_t;

endpackage

// File: rtl/prog_loader_word_asm.sv
// Little-endian byte-to-word assembler with running XOR checksum.
module loader_word_asm (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic [7:0]  xor_o,
  output logic        last_lane_o
);

  logic [1:0]  lane_q;
  logic [31:0] word_q;
  logic [7:0]  xor_q;
  logic        word_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q       <= '0;
      word_q       <= '0;
      xor_q        <= '0;
      word_valid_q <= 1'b0;
    end else if (clear_i) begin
      lane_q       <= '0;
      xor_q        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= byte_valid_i && (lane_q == 2'd3);
      if (byte_valid_i) begin
        word_q[{lane_q, 3'b000} +: 8] <= byte_i;
        xor_q                         <= xor_q ^ byte_i;
        lane_q                        <= lane_q + 2'd1;
      end
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
  assign xor_o        = xor_q;
  assign last_lane_o  = (lane_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Instruction-memory loader fed by a framed USB_CDC byte stream.
// Optional inactivity timeout: define PROG_LOADER_TIMEOUT_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = MEM_INSTR_ZERO,
  parameter int unsigned MAX_WORDS = 1024
`ifdef PROG_LOADER_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_rst_o,
  output logic        busy_o
);

  loader_state_t state_q, state_d;
  logic [7:0]    resp_d;
  logic [7:0]    len_lo_q;
  logic [15:0]   n_q;
  logic [15:0]   word_idx_q;
  logic [7:0]    in_data_q;
  logic          in_valid_q;
  logic          out_ready_q;
  logic          cpu_rst_q;
  logic [31:0]   mem_addr_q;

  logic          accept;
  logic          resp_hs;
  logic          ack_hs;
  logic [15:0]   n_full;
  logic          asm_clear;
  logic          asm_byte_valid;
  logic          asm_last_lane;
  logic [7:0]    asm_xor;
  logic          timeout;

  assign accept         = out_valid_i && out_ready_q;
  assign resp_hs        = in_valid_q && in_ready_i;
  assign ack_hs         = resp_hs && (in_data_q == LOADER_ACK);
  assign n_full         = {out_data_i, len_lo_q};
  assign asm_clear      = (state_q == IDLE) && accept && (out_data_i == LOADER_SYNC);
  assign asm_byte_valid = (state_q == DATA) && accept;

  loader_word_asm u_word_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_byte_valid),
    .byte_i       (out_data_i),
    .word_valid_o (mem_we_o),
    .word_o       (mem_wdata_o),
    .xor_o        (asm_xor),
    .last_lane_o  (asm_last_lane)
  );

`ifdef PROG_LOADER_TIMEOUT_EN
  logic [23:0] to_cnt_q;
  logic        counting;

  assign counting = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CSUM);
  assign timeout  = counting && (to_cnt_q == TIMEOUT_CYCLES);

  always_ff @(posedge clk_i) begin
    if (rst_i || accept || !counting) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 24'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    resp_d  = LOADER_NAK;
    unique case (state_q)
      IDLE:   if (accept && (out_data_i == LOADER_SYNC)) state_d = LEN_LO;
      LEN_LO: if (accept) state_d = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (n_full == 16'd0) begin
            state_d = CSUM;
          end else if ({16'd0, n_full} > MAX_WORDS) begin
            state_d = RESP;
            resp_d  = LOADER_NAK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept && asm_last_lane && (word_idx_q == n_q - 16'd1)) state_d = CSUM;
      end
      CSUM: begin
        if (accept) begin
          state_d = RESP;
          resp_d  = (out_data_i == asm_xor) ? LOADER_ACK : LOADER_NAK;
        end
      end
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A byte arriving on the expiry cycle wins; the counter restarts instead.
    if (timeout && !accept) begin
      state_d = RESP;
      resp_d  = LOADER_NAK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      out_ready_q <= 1'b0;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      cpu_rst_q   <= 1'b1;
      mem_addr_q  <= MEM_BASE;
      len_lo_q    <= '0;
      n_q         <= '0;
      word_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_ready_q <= (state_d != RESP);
      in_valid_q  <= (state_d == RESP);
      if ((state_q != RESP) && (state_d == RESP)) in_data_q <= resp_d;
      if (asm_clear) cpu_rst_q <= 1'b1;
      if (ack_hs)    cpu_rst_q <= 1'b0;
      if ((state_q == LEN_LO) && accept) len_lo_q <= out_data_i;
      if ((state_q == LEN_HI) && accept) begin
        n_q        <= n_full;
        word_idx_q <= '0;
      end
      if (asm_byte_valid && asm_last_lane) begin
        mem_addr_q <= MEM_BASE + {14'd0, word_idx_q, 2'b00};
        word_idx_q <= word_idx_q + 16'd1;
      end
    end
  end

  // Release is visible in the handshake cycle itself, not one cycle later.
  assign cpu_rst_o   = cpu_rst_q && !ack_hs;
  assign out_ready_o = out_ready_q;
  assign in_valid_o  = in_valid_q;
  assign in_data_o   = in_data_q;
  assign mem_addr_o  = mem_addr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed frames, queued expected writes/responses.
module tb_prog_loader;

  localparam logic [31:0] MB  = 32'h0000_1000;
  localparam logic [7:0]  ACK = 8'h06;
  localparam logic [7:0]  NAK = 8'h15;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  out_data_i;
  logic        out_valid_i;
  logic        out_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        cpu_rst_o;
  logic        busy_o;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] fr[$];
  int         vectors    = 0;
  int         miscompares = 0;
  logic       prev_we    = 1'b0;

  always #5 clk = ~clk;

  prog_loader #(
    .MEM_BASE  (MB),
    .MAX_WORDS (1024)
`ifdef PROG_LOADER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (24'd100)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .cpu_rst_o   (cpu_rst_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: samples just after the falling edge, once stimulus has settled.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mem_we_o) begin
        chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
        if (wq.size() == 0) begin
          chk("unexpected_write", mem_addr_o, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("write_addr", mem_addr_o, e.a);
          chk("write_data", mem_wdata_o, e.d);
        end
      end
      prev_we = mem_we_o;
      if (in_valid_o && in_ready_i) begin
        if (rq.size() == 0) begin
          chk("unexpected_resp", {24'd0, in_data_o}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] r;
          r = rq.pop_front();
          chk("resp_byte", {24'd0, in_data_o}, {24'd0, r});
          chk("cpu_rst_at_hs", {31'd0, cpu_rst_o}, (r == ACK) ? 32'd0 : 32'd1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    out_data_i  = b;
    out_valid_i = 1'b1;
    while (!out_ready_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!out_ready_o) begin
      vectors++;
      miscompares++;
      $display("FAIL out_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    out_valid_i = 1'b0;
  endtask

  task automatic send_fr();
    foreach (fr[i]) send_byte(fr[i]);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (rq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("resp_drained", rq.size(), 32'd0);
    chk("writes_drained", wq.size(), 32'd0);
    chk("idle_after_frame", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst_i       = 1'b1;
    out_data_i  = 8'h00;
    out_valid_i = 1'b0;
    in_ready_i  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_ready", {31'd0, out_ready_o}, 32'd0);
    chk("rst_in_valid", {31'd0, in_valid_o}, 32'd0);
    chk("rst_in_data", {24'd0, in_data_o}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, MB);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;

    // Two-word load; checksum 13^93^10 = 90.
    wq.push_back({MB + 32'd0, 32'h0000_0013});
    wq.push_back({MB + 32'd4, 32'h0010_0093});
    rq.push_back(ACK);
    fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_fr();
    @(negedge clk);
    #1;
    chk("cpu_held_before_csum", {31'd0, cpu_rst_o}, 32'd1);
    send_byte(8'h90);
    wait_done(50);
    chk("cpu_released_ack", {31'd0, cpu_rst_o}, 32'd0);

    // Same frame, bad checksum.
    wq.push_back({MB + 32'd0, 32'h0000_0013});
    wq.push_back({MB + 32'd4, 32'h0010_0093});
    rq.push_back(NAK);
    fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
    send_fr();
    wait_done(50);
    chk("cpu_held_nak", {31'd0, cpu_rst_o}, 32'd1);

    // Leading garbage, then an empty program.
    rq.push_back(ACK);
    fr = {8'h00, 8'hFF, 8'h41, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_fr();
    wait_done(50);
    chk("cpu_released_empty", {31'd0, cpu_rst_o}, 32'd0);

    // New header re-asserts reset; count 1025 is over the limit.
    send_byte(8'hA5);
    @(negedge clk);
    #1;
    chk("cpu_reassert_on_sync", {31'd0, cpu_rst_o}, 32'd1);
    chk("busy_after_sync", {31'd0, busy_o}, 32'd1);
    rq.push_back(NAK);
    fr = {8'h01, 8'h04};
    send_fr();
    wait_done(50);
    chk("cpu_held_oversize", {31'd0, cpu_rst_o}, 32'd1);

    // Host back-pressure on the response.
    in_ready_i = 1'b0;
    rq.push_back(ACK);
    fr = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_fr();
    begin
      int n = 0;
      while (!in_valid_o && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int unsigned c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("stall_in_valid", {31'd0, in_valid_o}, 32'd1);
      chk("stall_in_data", {24'd0, in_data_o}, {24'd0, ACK});
      chk("stall_out_ready", {31'd0, out_ready_o}, 32'd0);
    end
    @(negedge clk);
    in_ready_i = 1'b1;
    wait_done(50);

    // A sync byte inside the data is just data.
    wq.push_back({MB + 32'd0, 32'h0000_00A5});
    rq.push_back(ACK);
    fr = {8'hA5, 8'h01, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5};
    send_fr();
    wait_done(50);

    // Reset mid-frame, then a clean two-word load; checksum 08^22 = 2A.
    fr = {8'hA5, 8'h02, 8'h00, 8'h13};
    send_fr();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
    chk("midrst_out_ready", {31'd0, out_ready_o}, 32'd0);
    rst_i = 1'b0;
    wq.push_back({MB + 32'd0, 32'h1234_5678});
    wq.push_back({MB + 32'd4, 32'hDEAD_BEEF});
    rq.push_back(ACK);
    fr = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_fr();
    wait_done(50);
    chk("cpu_released_after_midrst", {31'd0, cpu_rst_o}, 32'd0);

`ifdef PROG_LOADER_TIMEOUT_EN
    // Stall after three data bytes; NAK after the idle limit.
    rq.push_back(NAK);
    fr = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    send_fr();
    repeat (90) @(negedge clk);
    #1;
    chk("timeout_not_early", {31'd0, in_valid_o}, 32'd0);
    wait_done(300);
    chk("cpu_held_timeout", {31'd0, cpu_rst_o}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
